// File: rtl/gemm_job_sched.sv
// gemm_job_sched
//   Two-requester job scheduler in front of a single gemm_core. A requester
//   is granted round-robin. It then streams 2*N_ELEM elements: N_ELEM m1
//   elements followed by N_ELEM m2 elements. The scheduler writes each element
//   into the core, pulses core_start, waits for core_done and returns the core
//   sum, tagged with the requester id, on a valid/ready result port.
//
//   Optional feature macro: GEMM_SCHED_TIMEOUT_EN. When it is defined, a job
//   whose done does not arrive within TIMEOUT_CYC cycles of core_start is
//   returned with res_err=1 and res_data=0.
//
// Ports
//   clk, rst_n         clock; reset is asynchronous and active-high
//   in_valid/in_ready  per-requester element handshake (bit i = requester i)
//   in_data            requester i element in [i*DATA_W +: DATA_W]
//   res_*              result channel: valid/ready, sum, requester id, error
//   core_wr_*          registered element write into the core (sel 0=m1, 1=m2)
//   core_start         one-cycle start pulse
//   core_done/sum      core completion level and result
module gemm_job_sched #(
  parameter int N_ELEM      = 256,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 21,
  parameter int SUM_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            in_valid,
  output logic [1:0]            in_ready,
  input  logic [2*DATA_W-1:0]   in_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SUM_W-1:0]      res_data,
  output logic                  res_id,
  output logic                  res_err,
  output logic                  core_wr_en,
  output logic [1:0]            core_wr_sel,
  output logic [ADDR_W-1:0]     core_wr_addr,
  output logic [DATA_W-1:0]     core_wr_data,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [SUM_W-1:0]      core_sum
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_START, S_WAIT_LO, S_WAIT_HI, S_RESULT
  } state_e;

  localparam int              BEAT_W    = ADDR_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2*N_ELEM-1);

  state_e              state_q;
  logic                gnt_q, ptr_q;     // ptr_q = requester favoured at next grant
  logic [BEAT_W-1:0]   beat_q;           // MSB selects m1/m2, low bits are the address
  logic                drain_q;
  logic                wr_en_q, start_q, res_valid_q, res_id_q, res_err_q;
  logic [1:0]          wr_sel_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [SUM_W-1:0]    res_data_q;

  logic                gnt_d, hs, waiting, tmo;
  logic [DATA_W-1:0]   gnt_data;

  assign in_ready = (state_q == S_LOAD) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign hs       = |(in_valid & in_ready);
  assign gnt_data = gnt_q ? in_data[2*DATA_W-1:DATA_W] : in_data[DATA_W-1:0];
  assign gnt_d    = in_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign waiting  = (state_q == S_WAIT_LO) || (state_q == S_WAIT_HI);

`ifdef GEMM_SCHED_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  // Counts cycles since core_start: it is 1 in the first wait cycle, so the
  // result appears exactly TIMEOUT_CYC cycles after the start pulse.
  logic [TMR_W-1:0] tmr_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                           tmr_q <= '0;
    else if (state_q == S_START)         tmr_q <= TMR_W'(1);
    else if (waiting && tmr_q != TMR_LAST) tmr_q <= tmr_q + 1'b1;
  end
  assign tmo = waiting && (tmr_q == TMR_LAST);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      ptr_q       <= 1'b0;
      beat_q      <= '0;
      drain_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (|in_valid) begin
          gnt_q   <= gnt_d;
          ptr_q   <= ~gnt_d;
          beat_q  <= '0;
          state_q <= S_LOAD;
        end
        S_LOAD: if (hs) begin
          wr_en_q   <= 1'b1;
          wr_sel_q  <= {1'b0, beat_q[ADDR_W]};
          wr_addr_q <= beat_q[ADDR_W-1:0];
          wr_data_q <= gnt_data;
          beat_q    <= beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            drain_q <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        // Two idle cycles keep the last write well clear of the start pulse.
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: state_q <= S_WAIT_LO;
        // A done level left over from the previous job must drop first.
        S_WAIT_LO: begin
          if (!core_done) state_q <= S_WAIT_HI;
          else if (tmo) begin
            res_valid_q <= 1'b1;
            res_data_q  <= '0;
            res_id_q    <= gnt_q;
            res_err_q   <= 1'b1;
            state_q     <= S_RESULT;
          end
        end
        S_WAIT_HI: begin
          if (core_done) begin
            res_valid_q <= 1'b1;
            res_data_q  <= core_sum;
            res_id_q    <= gnt_q;
            res_err_q   <= 1'b0;
            state_q     <= S_RESULT;
          end else if (tmo) begin
            res_valid_q <= 1'b1;
            res_data_q  <= '0;
            res_id_q    <= gnt_q;
            res_err_q   <= 1'b1;
            state_q     <= S_RESULT;
          end
        end
        S_RESULT: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_wr_en   = wr_en_q;
  assign core_wr_sel  = wr_sel_q;
  assign core_wr_addr = wr_addr_q;
  assign core_wr_data = wr_data_q;
  assign core_start   = start_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign res_err      = res_err_q;

endmodule
